// File: rtl/calc_display_pkg.sv
// Shared definitions for the calculator display path: segment constants
// (active-low, {g,f,e,d,c,b,a}) and the per-slot scan state.
package calc_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // GUARD: all anodes off between digits; ON: one anode driven.
  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Lookup table; lower-case glyphs for b and d keep them distinct from 8 and 0.
  always_comb begin
    seg = 7'b1111111;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit seven-segment scan controller. Each digit slot is a GUARD
// phase (anodes off, against ghosting) followed by an ON phase. New values
// arrive through a valid/ready handshake into a one-entry pending register
// and are promoted to the displayed value only at the end of a frame.
//
// Handshake: a transfer happens on a cycle where upd_valid && upd_ready at
// the rising clock edge. upd_ready is low exactly while the pending register
// holds a value; the source keeps upd_value/upd_neg stable while it waits.
module seg_scan_controller
  import calc_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_value,
  input  logic        upd_neg,
  input  logic        blank_en,
  output logic [1:0]  select,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CW = $clog2(DIGIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  // With no guard time every slot starts directly in ON.
  localparam scan_state_e FIRST_STATE = (GUARD_CYCLES == 0) ? ON : GUARD;

  scan_state_e   state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    digit, digit_next;

  logic [15:0] active_value, pend_value;
  logic        active_neg, pend_neg, pend_full;
  logic        accept;

  logic [3:0]  nib_zero;
  logic [3:0]  nibble;
  logic        lead_zero;
  logic [6:0]  hex_seg;
  logic [6:0]  digit_seg;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;

  // ---------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------

  // State register: slot phase, slot counter and the digit being scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST_STATE;
      cnt   <= '0;
      digit <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      digit <= digit_next;
    end
  end

  // Next state: counter runs through the whole slot; the slot end clears it
  // and advances the digit (2-bit wrap 3 -> 0).
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    digit_next = digit;
    case (state)
      GUARD: begin
        if (cnt == GUARD_LAST) state_next = ON;
      end
      ON: begin
        if (cnt == LAST_CNT) begin
          state_next = FIRST_STATE;
          cnt_next   = '0;
          digit_next = digit + 2'd1;
        end
      end
      default: state_next = FIRST_STATE;
    endcase
  end

  // Last cycle of the digit 3 slot: the only point where the value may change.
  assign frame_done = (state == ON) && (cnt == LAST_CNT) && (digit == 2'd3);

  // ---------------------------------------------------------------------
  // Update handshake and pending/active value registers
  // ---------------------------------------------------------------------

  assign upd_ready = !pend_full;
  assign accept    = upd_valid && upd_ready;

  // Capture offered values; promote pending to active at the frame boundary.
  // Acceptance and promotion are exclusive because ready is low while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value   <= 16'h0000;
      pend_neg     <= 1'b0;
      pend_full    <= 1'b0;
      active_value <= 16'h0000;
      active_neg   <= 1'b0;
    end else if (accept) begin
      pend_value <= upd_value;
      pend_neg   <= upd_neg;
      pend_full  <= 1'b1;
    end else if (frame_done && pend_full) begin
      active_value <= pend_value;
      active_neg   <= pend_neg;
      pend_full    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Digit pattern selection: minus, then leading-zero blank, then hex
  // ---------------------------------------------------------------------

  // Nibble 3 counts as zero when the minus sign occupies that position, so
  // the blanking run can reach down past it.
  assign nib_zero[0] = (active_value[3:0]   == 4'h0);
  assign nib_zero[1] = (active_value[7:4]   == 4'h0);
  assign nib_zero[2] = (active_value[11:8]  == 4'h0);
  assign nib_zero[3] = (active_value[15:12] == 4'h0) || active_neg;

  // Pick the scanned nibble and whether it and everything above it is zero.
  always_comb begin
    nibble    = active_value[3:0];
    lead_zero = 1'b0;
    case (digit)
      2'd0: nibble = active_value[3:0];
      2'd1: begin
        nibble    = active_value[7:4];
        lead_zero = &nib_zero[3:1];
      end
      2'd2: begin
        nibble    = active_value[11:8];
        lead_zero = &nib_zero[3:2];
      end
      2'd3: begin
        nibble    = active_value[15:12];
        lead_zero = nib_zero[3];
      end
      default: nibble = active_value[3:0];
    endcase
  end

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // Priority mux for the ON-phase pattern; blank_en is used live.
  always_comb begin
    digit_seg = hex_seg;
    if (digit == 2'd3 && active_neg) begin
      digit_seg = SEG_MINUS;
    end else if (blank_en && digit != 2'd0 && lead_zero) begin
      digit_seg = SEG_BLANK;
    end
  end

  // Anode/segment values for the current phase, before the output register.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_BLANK;
    if (state == ON) begin
      an_next  = ~(4'b0001 << digit);
      seg_next = digit_seg;
    end
  end

  // Output register: an, seg and select change on the same edge, so the
  // pins never show a digit index paired with another digit's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an     <= 4'b1111;
      seg    <= SEG_BLANK;
      select <= 2'd0;
    end else begin
      an     <= an_next;
      seg    <= seg_next;
      select <= digit;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with DIGIT_CYCLES=8, GUARD_CYCLES=2.
// Expected digit patterns are queued when a value is sent and consumed
// slot by slot while a displayed frame is observed.
module tb_seg_scan_controller;

  localparam int DC = 8;
  localparam int GC = 2;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_MINUS = 7'b0111111;
  localparam logic [6:0] P_0 = 7'b1000000;
  localparam logic [6:0] P_1 = 7'b1111001;
  localparam logic [6:0] P_2 = 7'b0100100;
  localparam logic [6:0] P_3 = 7'b0110000;
  localparam logic [6:0] P_4 = 7'b0011001;
  localparam logic [6:0] P_A = 7'b0001000;
  localparam logic [6:0] P_B = 7'b0000011;

  logic        clk;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_value;
  logic        upd_neg;
  logic        blank_en;
  logic [1:0]  select;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] exp_q[$];

  seg_scan_controller #(
    .DIGIT_CYCLES (DC),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_value  (upd_value),
    .upd_neg    (upd_neg),
    .blank_en   (blank_en),
    .select     (select),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer a value (called at a falling edge) and wait, bounded, for acceptance.
  task automatic send(input logic [15:0] v, input logic n);
    bit ok;
    ok = 1'b0;
    upd_value = v;
    upd_neg   = n;
    upd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (upd_ready) ok = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    check("send_accept", ok, 1);
    check("ready_drop", upd_ready, 0);
  endtask

  task automatic push4(input logic [6:0] d0, input logic [6:0] d1,
                       input logic [6:0] d2, input logic [6:0] d3);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
  endtask

  // Stops at the falling edge where frame_done is high, or after a bound.
  task automatic wait_frame_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_seen", seen, 1);
  endtask

  // Observe one full displayed frame (4 slots x 8 cycles) at the outputs.
  // skip=1 when called right at a frame_done falling edge: the outputs lag
  // the internal scan by one cycle, so digit 3's last ON cycle is still out.
  task automatic watch_frame(input bit skip);
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    if (skip) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check("sb_nonempty", (exp_q.size() != 0), 1);
      exp_seg = (exp_q.size() != 0) ? exp_q.pop_front() : 7'bxxxxxxx;
      exp_an  = ~(4'b0001 << s);
      for (int c = 0; c < DC; c++) begin
        @(negedge clk);
        check($sformatf("select d%0d c%0d", s, c), select, s[1:0]);
        if (c < GC) begin
          check($sformatf("guard_an d%0d c%0d", s, c), an, 4'b1111);
          check($sformatf("guard_seg d%0d c%0d", s, c), seg, P_BLANK);
        end else begin
          check($sformatf("on_an d%0d c%0d", s, c), an, exp_an);
          check($sformatf("on_seg d%0d c%0d", s, c), seg, exp_seg);
        end
        check($sformatf("frame_done d%0d c%0d", s, c), frame_done, (s == 3 && c == DC - 2));
        if (s == 0 && c == 0 && upd_valid) begin
          check("bp_ready_low", upd_ready, 0);
          upd_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    upd_valid = 1'b0;
    upd_value = 16'h0000;
    upd_neg   = 1'b0;
    blank_en  = 1'b0;

    // Reset, run into a slot, load a pending value, then reset mid-slot.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(16'h9999, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, P_BLANK);
    check("rst_select", select, 2'd0);
    check("rst_ready", upd_ready, 1);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First slot after release: 2 guard cycles, then digit 0 of value 0.
    for (int c = 0; c < DC; c++) begin
      @(negedge clk);
      check($sformatf("post_rst_an c%0d", c), an, (c < GC) ? 4'b1111 : 4'b1110);
      check($sformatf("post_rst_seg c%0d", c), seg, (c < GC) ? P_BLANK : P_0);
      check($sformatf("post_rst_sel c%0d", c), select, 2'd0);
    end

    // Plain display of 1234.
    blank_en = 1'b0;
    send(16'h1234, 1'b0);
    push4(P_4, P_3, P_2, P_1);
    wait_frame_done();
    watch_frame(1'b1);

    // Negative with leading-zero suppression.
    blank_en = 1'b1;
    send(16'h0042, 1'b1);
    push4(P_2, P_4, P_BLANK, P_MINUS);
    wait_frame_done();
    watch_frame(1'b1);

    // All zeros with suppression: only digit 0 lit.
    send(16'h0000, 1'b0);
    push4(P_0, P_BLANK, P_BLANK, P_BLANK);
    wait_frame_done();
    watch_frame(1'b1);

    // Backpressure: AAAA taken, BBBB held until the pending slot frees.
    blank_en  = 1'b0;
    upd_value = 16'hAAAA;
    upd_neg   = 1'b0;
    upd_valid = 1'b1;
    check("bp_ready_first", upd_ready, 1);
    @(negedge clk);
    check("bp_ready_after_a", upd_ready, 0);
    upd_value = 16'hBBBB;
    push4(P_A, P_A, P_A, P_A);
    wait_frame_done();
    check("bp_ready_held", upd_ready, 0);
    @(negedge clk);
    check("bp_ready_after_fd", upd_ready, 1);
    push4(P_B, P_B, P_B, P_B);
    watch_frame(1'b0);
    watch_frame(1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display on the calculator.
- Cycles the digit select, drives active-low anodes, and inserts the minus sign on digit 3 when the result is negative.
- Suppresses leading zeros and blanks anodes for a ghosting guard between digits.
- Takes new results through a valid/ready handshake and applies them only at frame boundaries, so a displayed frame never mixes two values.

Parameters:
- DIGIT_CYCLES, 100000: total clock cycles per digit slot, guard included. Legal range: GUARD_CYCLES+1 and above.
- GUARD_CYCLES, 1000: cycles at the start of each slot with all anodes off.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- upd_valid  in  1  new display value offered
- upd_ready  out  1  controller can accept a value
- upd_value  in  16  four BCD/hex nibbles; [3:0] is digit 0 (rightmost)
- upd_neg  in  1  value is negative
- blank_en  in  1  enable leading-zero suppression (level input, sampled live)
- select  out  2  current digit index, 0..3
- an  out  4  anodes, active-low, one-hot-low during the ON phase
- seg  out  7  segments, active-low, {g,f,e,d,c,b,a}
- frame_done  out  1  one-cycle pulse at the last cycle of the digit 3 slot

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously clears all state.
  - Outputs at reset: an=4'b1111, seg=7'b1111111, select=0, frame_done=0, upd_ready=1.
  - Internal state at reset: active value 0, active neg 0, pending empty, slot counter 0, FSM=GUARD.
- FSM states, per slot:
  - GUARD: counter runs 0..GUARD_CYCLES-1; an=4'b1111; seg=7'b1111111.
  - ON: counter runs GUARD_CYCLES..DIGIT_CYCLES-1; an[select]=0; seg = pattern for the digit.
- FSM transitions:
  - GUARD to ON when the counter reaches GUARD_CYCLES-1.
  - ON to GUARD when the counter reaches DIGIT_CYCLES-1; on that transition the counter clears and select increments, wrapping 3 to 0.
  - If GUARD_CYCLES=0, GUARD is skipped entirely.
- Output registering: an, seg and select are registered together, with one cycle of latency from the counter/state. No output glitches between them.
- Digit pattern priority, for digit i with nibble d:
  1. Minus: i==3 and active neg=1 gives seg=7'b0111111.
  2. Leading-zero blank: blank_en=1, i!=0, and nibbles i..3 all zero (digit 3 ignored when the minus is shown) gives seg=7'b1111111.
  3. Otherwise the hex decode of d: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Update handshake:
  - A transfer occurs on upd_valid && upd_ready; upd_value and upd_neg are captured into the pending register.
  - upd_ready = !pending_full; it drops the cycle after acceptance.
- Pending to active:
  - At frame_done, a full pending register copies into active and pending clears.
  - Pending clearing and a same-cycle acceptance do not both happen: ready is low while pending is full.
  - A new value becomes visible starting at the next digit 0 slot.
- Frame boundary: frame_done is asserted in the cycle where select==3, state ON, and counter==DIGIT_CYCLES-1.
- Hold behaviour: upd_valid may be held high; upd_value must be stable while upd_valid && !upd_ready.
- Reset mid-frame: returns to the digit 0 GUARD state immediately; any pending value is discarded.

Decomposition:
- Shared package calc_display_pkg holds:
  - SEG_BLANK=7'b1111111 and SEG_MINUS=7'b0111111
  - the scan state enum {GUARD, ON}
- Sub-module seg7_hex_decode: a combinational 4-bit to 7-bit active-low decode table.
- The priority mux (minus, blank, decode) and the FSM stay in the top module.

Test Plan:
- Bench parameters for all scenarios: DIGIT_CYCLES=8, GUARD_CYCLES=2.
- Reset check: assert rst_n low mid-slot -> an=1111, seg=1111111, select=0, upd_ready=1. Then release -> 2 guard cycles, then an=1110 for 6 cycles.
- Plain display: send upd_value=16'h1234, upd_neg=0, blank_en=0 -> after the next frame_done, digits 0..3 show 0110011 is not used; the required sequence is 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1). frame_done pulses every 32 cycles.
- Negative with suppression: send 16'h0042, upd_neg=1, blank_en=1 -> digit 0=0100100, digit 1=0011001, digit 2=1111111, digit 3=0111111.
- All-zero suppression: send 16'h0000, blank_en=1, neg=0 -> digits 1..3 blank, digit 0=1000000.
- Handshake backpressure: hold upd_valid with 16'hAAAA, then change to 16'hBBBB once ready is low -> the second value is not accepted until after frame_done. The display changes only at a frame boundary, with no mixed frame.
- Ghosting guard: for every slot, an==1111 for exactly 2 cycles. Anodes are never low simultaneously for two digits.
